// File: rtl/div_recon_mul.sv
// Rebuilds a dividend as quotient*divisor + remainder with a shift-add multiplier.
// Optional DIV_RECON_CHECK_EN adds a reference-dividend compare and a mismatch counter.
module div_recon_mul #(
    parameter int QUOTIENT_BITDEPTH  = 16,
    parameter int DIVISOR_BITDEPTH   = 16,
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic                                        i_sclk,
    input  logic                                        i_rst,
    input  logic                                        i_input_valid,
    output logic                                        o_input_ready,
    input  logic [QUOTIENT_BITDEPTH-1:0]                i_quotient,
    input  logic [DIVISOR_BITDEPTH-1:0]                 i_divisor,
    input  logic [DIVISOR_BITDEPTH-1:0]                 i_remainder,
    output logic                                        o_output_valid,
    output logic [QUOTIENT_BITDEPTH+DIVISOR_BITDEPTH-1:0] o_product,
    output logic [QUOTIENT_BITDEPTH-1:0]                o_dividend,
    output logic                                        o_overflow,
    output logic                                        o_rem_error
`ifdef DIV_RECON_CHECK_EN
    ,
    input  logic [QUOTIENT_BITDEPTH-1:0]                i_ref_dividend,
    output logic                                        o_mismatch,
    output logic [15:0]                                 o_mismatch_cnt
`endif
);

    localparam int Q     = QUOTIENT_BITDEPTH;
    localparam int D     = DIVISOR_BITDEPTH;
    localparam int K     = MUL_BITS_PER_CYCLE;
    localparam int W     = Q + D;
    localparam int STEPS = Q / K;
    localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    if (Q % K != 0) begin : g_bad_k
        $error("MUL_BITS_PER_CYCLE must divide QUOTIENT_BITDEPTH");
    end
    if (D > Q) begin : g_bad_d
        $error("DIVISOR_BITDEPTH must not exceed QUOTIENT_BITDEPTH");
    end

    typedef enum logic {IDLE, MUL} state_t;

    state_t        state;
    logic [W-1:0]  acc;
    logic [W-1:0]  md;
    logic [Q-1:0]  mq;
    logic [SW-1:0] step;
    logic          rem_err_r;
    logic [W-1:0]  acc_nxt;
    logic          last;

    assign o_input_ready = (state == IDLE);
    assign acc_nxt = acc + md * {{(W-K){1'b0}}, mq[K-1:0]};
    assign last    = (step == SW'(STEPS - 1));

    always_ff @(posedge i_sclk or posedge i_rst) begin
        if (i_rst) begin
            state          <= IDLE;
            acc            <= '0;
            md             <= '0;
            mq             <= '0;
            step           <= '0;
            rem_err_r      <= 1'b0;
            o_output_valid <= 1'b0;
            o_product      <= '0;
            o_dividend     <= '0;
            o_overflow     <= 1'b0;
            o_rem_error    <= 1'b0;
        end else begin
            o_output_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_input_valid) begin
                        acc       <= W'(i_remainder);
                        mq        <= i_quotient;
                        md        <= W'(i_divisor);
                        step      <= '0;
                        rem_err_r <= (i_divisor == '0) || (i_remainder >= i_divisor);
                        state     <= MUL;
                    end
                end
                MUL: begin
                    acc  <= acc_nxt;
                    md   <= md << K;
                    mq   <= mq >> K;
                    step <= step + SW'(1);
                    if (last) begin
                        o_product      <= acc_nxt;
                        o_dividend     <= acc_nxt[Q-1:0];
                        o_overflow     <= |acc_nxt[W-1:Q];
                        o_rem_error    <= rem_err_r;
                        o_output_valid <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DIV_RECON_CHECK_EN
    logic [Q-1:0] ref_r;
    logic         mm_nxt;

    assign mm_nxt = (acc_nxt != W'(ref_r)) || rem_err_r;

    always_ff @(posedge i_sclk or posedge i_rst) begin
        if (i_rst) begin
            ref_r          <= '0;
            o_mismatch     <= 1'b0;
            o_mismatch_cnt <= '0;
        end else begin
            if (o_input_ready && i_input_valid)
                ref_r <= i_ref_dividend;
            if (state == MUL && last) begin
                o_mismatch <= mm_nxt;
                if (mm_nxt && o_mismatch_cnt != 16'hFFFF)
                    o_mismatch_cnt <= o_mismatch_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
